uart_receiver: RTL
==================

# uart_receiver

Serial receive front end for the pipelined CPU's UART peripheral. It takes the raw asynchronous UART_RX pin and produces 8N1 frames as bytes, with no parity, LSB first and one stop bit. Received bytes go into a small first-word-fall-through FIFO, which the CPU's peripheral read path drains one byte at a time through a valid/ready pop. It also flags framing and overrun errors for the UART status register.

## Interface
- CLKS_PER_BIT, default 16: clock cycles per bit period. Must be even and ≥ 4.
- FIFO_DEPTH, default 4: number of buffered bytes. Must be a power of two and ≥ 2.

- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- UART_RX  in  1  asynchronous serial line; idles high.
- rx_data  out  8  byte at the FIFO head. Valid only while rx_valid=1.
- rx_valid  out  1  FIFO is non-empty.
- rx_ready  in  1  pop request. A pop occurs when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- busy  out  1  high in any state other than IDLE.

## Operation
- UART_RX passes through a 2-flop synchronizer. The synchronizer flops reset to 1. The FSM uses only the synchronized signal rxs and its previous value.
- The FSM has states IDLE, START, DATA, STOP and BREAK_WAIT. Let H = CLKS_PER_BIT/2.
- IDLE:
  - On a falling edge of rxs (previous 1, current 0), go to START and load the bit counter.
- START:
  - After H cycles, sample rxs.
  - If rxs=1 it was a false start: return to IDLE with no error.
  - If rxs=0, go to DATA with bit index 0.
- DATA:
  - Sample every CLKS_PER_BIT cycles.
  - Shift each sample into bit[index], LSB first.
  - After index 7, go to STOP.
- STOP:
  - Sample CLKS_PER_BIT cycles after bit 7.
  - If rxs=1 the byte is good: push it to the FIFO and go to IDLE.
  - If rxs=0, pulse frame_err, discard the byte and go to BREAK_WAIT.
- BREAK_WAIT: stay until rxs=1, then go to IDLE. This prevents a held-low line from being read as repeated starts.
- FIFO push and pop:
  - A push when the FIFO is full drops the new byte and pulses overrun. The existing contents are unchanged.
  - A push and a pop in the same cycle both take effect, including when the FIFO is full. In that case there is no overrun and the count is unchanged.
  - A pop when the FIFO is empty is ignored.
  - Read and write pointers have log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full and empty are derived from the pointer MSB and the lower bits.
- Reset values:
  - FSM state: IDLE.
  - FIFO: empty.
  - rx_valid=0, frame_err=0, overrun=0, busy=0, rx_data=8'h00.
- Reset asserted mid-frame aborts the frame. No push and no error pulse occur.

## Timing
- Let D0 be the clk edge at which IDLE detects the falling edge of rxs. This is 2–3 cycles after the pin falls, because of the synchronizer and phase.
- Samples are taken at:
  - start bit: D0+H;
  - data bit i: D0+H+(i+1)·CLKS_PER_BIT;
  - stop bit: D0+H+9·CLKS_PER_BIT. With the defaults this is D0+152.
- Effects of the stop sample:
  - The push, the frame_err pulse or the overrun pulse is registered on the stop-sample edge.
  - Those outputs are visible in the cycle after that edge.
  - rx_valid rises in that same next cycle if the FIFO was empty.
- The FSM returns to IDLE on the stop-sample edge, so a start bit immediately following is detected with no extra gap.
- rx_data changes only on a pop, or on a push into an empty FIFO. It is stable while rx_valid=1 and rx_ready=0.
- rx_ready is combinationally independent of every output. There is no combinational path from rx_ready to rx_valid within the same cycle.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (rx_state_t);
  - UART_DATA_BITS=8;
  - the default CLKS_PER_BIT.
- These are shared with the future transmitter.
- Sub-module uart_rx_fifo is a parameterised FWFT FIFO with ports push, push_data, pop, rd_data, valid, full and drop. The FSM, synchronizer and counters stay in uart_receiver.

## Test plan
- Good frame:
  - Stimulus: 0x18 sent with the defaults and 32-time-unit bits (16 clk), stop bit high.
  - Required: rx_valid=1 and rx_data=8'h18 at D0+153; frame_err never pulses.
- Back-to-back frames:
  - Stimulus: 0x24 then 0x48 with zero idle between them, rx_ready=0.
  - Required: FIFO count reaches 2. Pops return 0x24 then 0x48, after which rx_valid=0.
- Framing error:
  - Stimulus: 0x18 with the line held low for 5 bit times after bit 7.
  - Required: one frame_err pulse, no push, busy held in BREAK_WAIT until the line rises, then a following 0x24 frame is received correctly.
- False start: a 4-clk low glitch → return to IDLE at D0+8, with no push and no errors.
- Overrun with a full FIFO:
  - Stimulus: 5 frames 0x01–0x05 with rx_ready=0.
  - Required: one overrun pulse on the fifth frame; pops return 0x01–0x04.
  - Stimulus: repeat, with rx_ready=1 on the stop-sample cycle of the fifth frame.
  - Required: no overrun; 0x05 is retained.
- Mid-frame reset: reset pulsed during DATA bit 3 → all outputs at reset values; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and the receive FSM states.
// Kept separate so the transmitter can reuse them.
package uart_pkg;

   localparam int UART_DATA_BITS        = 8;
   localparam int UART_CLKS_PER_BIT_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK_WAIT
   } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receive FSM and the CPU read path.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic              valid,
   output logic              full,
   output logic              drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

   logic w_empty;
   logic w_pop_ok;
   logic w_push_ok;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign valid     = ~w_empty;
   assign w_pop_ok  = pop & ~w_empty;
   assign w_push_ok = push & (~full | w_pop_ok);
   assign drop      = push & full & ~w_pop_ok;
   assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: pin synchronizer, mid-bit sampling FSM and a FWFT byte FIFO,
// with one-cycle framing-error and overrun pulses for the status register.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      UART_RX,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_err,
   output logic                      overrun,
   output logic                      busy
);

   localparam int HALF  = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(UART_DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

   logic                      r_sync1;
   logic                      r_sync2;
   logic                      r_rxs_d;
   rx_state_t                 r_state;
   logic [CNT_W-1:0]          r_cnt;
   logic [IDX_W-1:0]          r_bit_idx;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic                      r_frame_err;
   logic                      r_overrun;

   rx_state_t        w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [IDX_W-1:0] w_idx_nxt;
   logic             w_rxs;
   logic             w_tick;
   logic             w_push;
   logic             w_ferr;
   logic             w_sample_bit;
   logic             w_fifo_full;
   logic             w_fifo_drop;

   assign w_rxs  = r_sync2;
   assign w_tick = (r_cnt == '0);

   // Synchronizer and edge-history flops idle high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_rxs_d     <= 1'b1;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_sync1     <= UART_RX;
         r_sync2     <= r_sync1;
         r_rxs_d     <= r_sync2;
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit_idx   <= w_idx_nxt;
         r_frame_err <= w_ferr;
         r_overrun   <= w_fifo_drop & w_fifo_full;
      end
   end

   always_ff @(posedge clk) begin
      if (w_sample_bit) r_shift[r_bit_idx] <= w_rxs;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_idx_nxt    = r_bit_idx;
      w_push       = 1'b0;
      w_ferr       = 1'b0;
      w_sample_bit = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_rxs_d && !w_rxs) begin
               w_state_nxt = START;
               w_cnt_nxt   = CNT_HALF;
            end
         end
         START: begin
            if (w_tick) begin
               if (w_rxs) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = DATA;
                  w_cnt_nxt   = CNT_FULL;
                  w_idx_nxt   = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         DATA: begin
            if (w_tick) begin
               w_sample_bit = 1'b1;
               w_cnt_nxt    = CNT_FULL;
               if (r_bit_idx == IDX_LAST) w_state_nxt = STOP;
               else                       w_idx_nxt   = r_bit_idx + IDX_W'(1);
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         STOP: begin
            if (w_tick) begin
               if (w_rxs) begin
                  w_push      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = BREAK_WAIT;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         BREAK_WAIT: begin
            if (w_rxs) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   uart_rx_fifo #(
      .DATA_W     (UART_DATA_BITS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push),
      .push_data (r_shift),
      .pop       (rx_ready),
      .rd_data   (rx_data),
      .valid     (rx_valid),
      .full      (w_fifo_full),
      .drop      (w_fifo_drop)
   );

   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != IDLE);

endmodule
